// File: rtl/rdcla_pkg.sv
// Shared types and helpers for the recursive-doubling carry-lookahead adder.
// Carry status encoding, the doubling combine operator and latency helper.
package rdcla_pkg;

    typedef enum logic [1:0] {
        KPG_K = 2'b00,
        KPG_P = 2'b01,
        KPG_G = 2'b11
    } kpg_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

    function automatic int latency_f(input int width);
        return $clog2(width) + 2;
    endfunction

    function automatic kpg_t kpg_status_f(input logic a_bit, input logic b_bit);
        if (a_bit && b_bit) begin
            return KPG_G;
        end else if (a_bit || b_bit) begin
            return KPG_P;
        end
        return KPG_K;
    endfunction

    function automatic kpg_t kpg_combine_f(input kpg_t cur, input kpg_t prev);
        return (cur == KPG_P) ? prev : cur;
    endfunction

endpackage

// File: rtl/rdcla_pipe_kpg_cell.sv
// One doubling node: a propagating position inherits the status of the
// position 2^(s-1) below it, otherwise it keeps its own.
module kpg_cell
    import rdcla_pkg::*;
(
    input  kpg_t cur_i,
    input  kpg_t prev_i,
    output kpg_t res_o
);

    assign res_o = kpg_combine_f(cur_i, prev_i);

endmodule

// File: rtl/rdcla_pipe.sv
// Pipelined recursive-doubling carry-lookahead adder/subtractor with
// valid/ready flow control, whole-pipeline stall and a sideband tag.
module rdcla_pipe
    import rdcla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG2W = $clog2(WIDTH),
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    logic             adv;
    logic [WIDTH-1:0] b_e;
    logic             c_e;
    logic [WIDTH:0]   carry;

    kpg_t             st_q  [LOG2W+1][WIDTH+1];
    kpg_t             st_d  [LOG2W+1][WIDTH+1];
    logic [WIDTH-1:0] a_q   [LOG2W+1];
    logic [WIDTH-1:0] be_q  [LOG2W+1];
    logic [TAG_W-1:0] tag_q [LOG2W+1];
    logic [LOG2W:0]   vld_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign b_e      = sub ? ~b : b;
    assign c_e      = sub ? ~cin : cin;

    assign st_d[0][0] = c_e ? KPG_G : KPG_K;
    for (genvar i = 1; i <= WIDTH; i++) begin : g_status
        assign st_d[0][i] = kpg_status_f(a[i-1], b_e[i-1]);
    end

    for (genvar s = 1; s <= LOG2W; s++) begin : g_stage
        for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
            if (i >= (1 << (s - 1))) begin : g_cmb
                kpg_cell u_cell (
                    .cur_i  (st_q[s-1][i]),
                    .prev_i (st_q[s-1][i-(1 << (s - 1))]),
                    .res_o  (st_d[s][i])
                );
            end else begin : g_pass
                assign st_d[s][i] = st_q[s-1][i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i] = (st_q[LOG2W][i] == KPG_G);
    end
    // The MSB position's doubling span stops at bit 1, one short of the
    // carry-in slot, so an all-propagate word is resolved against position 0.
    assign carry[WIDTH] = (kpg_combine_f(st_q[LOG2W][WIDTH], st_q[LOG2W][0]) == KPG_G);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s <= LOG2W; s++) begin
                for (int i = 0; i <= WIDTH; i++) begin
                    st_q[s][i] <= KPG_K;
                end
                a_q[s]   <= '0;
                be_q[s]  <= '0;
                tag_q[s] <= '0;
            end
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[LOG2W-1:0], in_valid};
            if (in_valid) begin
                for (int i = 0; i <= WIDTH; i++) begin
                    st_q[0][i] <= st_d[0][i];
                end
                a_q[0]   <= a;
                be_q[0]  <= b_e;
                tag_q[0] <= tag;
            end
            for (int s = 1; s <= LOG2W; s++) begin
                for (int i = 0; i <= WIDTH; i++) begin
                    st_q[s][i] <= st_d[s][i];
                end
                a_q[s]   <= a_q[s-1];
                be_q[s]  <= be_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            out_valid_q <= vld_q[LOG2W];
            if (vld_q[LOG2W]) begin
                sum_q     <= a_q[LOG2W] ^ be_q[LOG2W] ^ carry[WIDTH-1:0];
                cout_q    <= carry[WIDTH];
                ovf_q     <= carry[WIDTH] ^ carry[WIDTH-1];
                out_tag_q <= tag_q[LOG2W];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_tag   = out_tag_q;

endmodule
